// File: rtl/ahb_burst_arbiter.sv
// Four-master round-robin AHB arbiter. Holds the grant across fixed bursts, INCR bursts and
// locked sequences, and pipelines HMASTER / HMASTLOCK / data-phase owner on HREADY.
module ahb_burst_arbiter #(
  parameter int unsigned DEF_MASTER  = 0,
  parameter int unsigned NUM_BEATS_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       r0,
  input  logic       r1,
  input  logic       r2,
  input  logic       r3,
  input  logic [3:0] lock,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  output logic       gr0,
  output logic       gr1,
  output logic       gr2,
  output logic       gr3,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_d,
  output logic       hmastlock
);

  localparam logic [1:0] DefIdx      = 2'(DEF_MASTER);
  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {StArb, StBurst, StIncr, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [NUM_BEATS_W-1:0] cnt_q, cnt_d;
  logic [3:0]             grant_q, grant_d, req;
  logic [1:0]             ptr_q, ptr_d, grant_idx, rr_winner, cand;
  logic [1:0]             hmaster_q, hmaster_dph_q;
  logic                   hmastlock_q, rr_found;
  logic                   owner_req, owner_lock, nonseq_acc, seq_acc, term_acc;

  assign req        = {r3, r2, r1, r0};
  assign owner_req  = req[hmaster_q];
  assign owner_lock = lock[hmaster_q];
  assign nonseq_acc = hready && (htrans == TransNonseq);
  assign seq_acc    = hready && (htrans == TransSeq);
  assign term_acc   = hready && ((htrans == TransIdle) || (htrans == TransNonseq));

  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) grant_idx = 2'(i);
    end
  end

  // Search ptr+1, ptr+2, ptr+3, then ptr itself; park on the default master when idle.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = DefIdx;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!rr_found && req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StArb: begin
        if (nonseq_acc) begin
          if (owner_lock) begin
            state_d = StLocked;
          end else begin
            case (hburst)
              3'b001:         state_d = StIncr;
              3'b010, 3'b011: begin state_d = StBurst; cnt_d = NUM_BEATS_W'(3);  end
              3'b100, 3'b101: begin state_d = StBurst; cnt_d = NUM_BEATS_W'(7);  end
              3'b110, 3'b111: begin state_d = StBurst; cnt_d = NUM_BEATS_W'(15); end
              default:        state_d = StArb;
            endcase
          end
        end
      end
      StBurst: begin
        // BUSY beats and wait states leave the counter alone.
        if (seq_acc) begin
          if (cnt_q == NUM_BEATS_W'(1)) begin
            state_d = StArb;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - NUM_BEATS_W'(1);
          end
        end else if (term_acc) begin
          state_d = StArb;
          cnt_d   = '0;
        end
      end
      StIncr: begin
        if (!owner_req || term_acc) state_d = StArb;
      end
      StLocked: begin
        if (!owner_lock && hready) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  // Re-arbitrate only in cycles that end in ARB, so a release and a new grant share a cycle.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (enable && (state_d == StArb)) begin
      grant_d = 4'b0001 << rr_winner;
      if (rr_found) ptr_d = rr_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StArb;
      cnt_q         <= '0;
      grant_q       <= 4'b0001 << DefIdx;
      ptr_q         <= DefIdx;
      hmaster_q     <= DefIdx;
      hmaster_dph_q <= DefIdx;
      hmastlock_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      if (hready) begin
        hmaster_q     <= grant_idx;
        hmaster_dph_q <= hmaster_q;
        hmastlock_q   <= lock[grant_idx];
      end
    end
  end

  assign {gr3, gr2, gr1, gr0} = grant_q;
  assign hmaster              = hmaster_q;
  assign hmaster_d            = hmaster_dph_q;
  assign hmastlock            = hmastlock_q;

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Self-checking bench for ahb_burst_arbiter: directed scenarios plus a random run, all
// compared against a transaction-level model of the arbitration rules.
module tb_ahb_burst_arbiter;

  localparam int DEF = 0;

  logic       clk = 1'b0;
  logic       reset, enable, r0, r1, r2, r3, hready;
  logic [3:0] lock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       gr0, gr1, gr2, gr3, hmastlock;
  logic [1:0] hmaster, hmaster_d;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  ahb_burst_arbiter #(.DEF_MASTER(DEF), .NUM_BEATS_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .lock(lock),
    .hready(hready), .htrans(htrans), .hburst(hburst),
    .gr0(gr0), .gr1(gr1), .gr2(gr2), .gr3(gr3),
    .hmaster(hmaster), .hmaster_d(hmaster_d), .hmastlock(hmastlock)
  );

  always #5 clk = ~clk;

  // Model state: who holds the grant, what the bus is doing, and SEQ beats still owed.
  int    m_grant, m_ptr, m_hm, m_hmd, m_hml, m_left;
  string m_mode;
  int    n_grant, n_ptr, n_hm, n_hmd, n_hml, n_left;
  string n_mode;

  function automatic void model_predict();
    logic [3:0] req;
    int         owner, t, b, pick;
    req = {r3, r2, r1, r0};
    t   = int'(htrans);
    b   = int'(hburst);
    if (reset) begin
      n_grant = DEF; n_ptr = DEF; n_hm = DEF; n_hmd = DEF; n_hml = 0;
      n_mode = "arb"; n_left = 0;
      return;
    end
    owner  = m_hm;
    n_mode = m_mode;
    n_left = m_left;
    if (m_mode == "arb") begin
      if (hready && t == 2) begin
        if (lock[owner]) n_mode = "lock";
        else if (b == 1) n_mode = "incr";
        else if (b >= 2) begin
          n_mode = "burst";
          n_left = (4 << ((b - 2) / 2)) - 1;
        end
      end
    end else if (m_mode == "burst") begin
      if (hready && t == 3) begin
        n_left = m_left - 1;
        if (n_left == 0) n_mode = "arb";
      end else if (hready && (t == 0 || t == 2)) begin
        n_mode = "arb";
        n_left = 0;
      end
    end else if (m_mode == "incr") begin
      if (!req[owner] || (hready && (t == 0 || t == 2))) n_mode = "arb";
    end else begin
      if (!lock[owner] && hready) n_mode = "arb";
    end
    n_grant = m_grant;
    n_ptr   = m_ptr;
    if (enable && n_mode == "arb") begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      end
      if (pick >= 0) begin
        n_grant = pick;
        n_ptr   = pick;
      end else begin
        n_grant = DEF;
      end
    end
    n_hm = m_hm; n_hmd = m_hmd; n_hml = m_hml;
    if (hready) begin
      n_hm  = m_grant;
      n_hmd = m_hm;
      n_hml = int'(lock[m_grant]);
    end
  endfunction

  function automatic logic [8:0] model_bus();
    logic [3:0] g;
    g = 4'b0001 << m_grant;
    return {g, 2'(m_hm), 2'(m_hmd), 1'(m_hml)};
  endfunction

  function automatic logic [8:0] dut_bus();
    return {gr3, gr2, gr1, gr0, hmaster, hmaster_d, hmastlock};
  endfunction

  task automatic tick();
    model_predict();
    @(posedge clk);
    #1;
    cyc++;
    m_grant = n_grant; m_ptr = n_ptr; m_hm = n_hm; m_hmd = n_hmd; m_hml = n_hml;
    m_mode = n_mode; m_left = n_left;
  endtask

  task automatic set_idle();
    reset = 1'b0; enable = 1'b1; hready = 1'b1;
    {r3, r2, r1, r0} = 4'b0000;
    lock = 4'b0000; htrans = 2'b00; hburst = 3'b000;
  endtask

  task automatic pulse_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (dut_bus() !== 9'b0001_00_00_0) begin
      n_bad++;
      $display("FAIL reset_values: got %b want %b", dut_bus(), 9'b0001_00_00_0);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (dut_bus() !== 9'b0001_00_00_0 || dut_bus() !== model_bus()) begin
        n_bad++;
        $display("FAIL reset_park cyc %0d: got %b want %b", i, dut_bus(), 9'b0001_00_00_0);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] want;
    pulse_reset();
    {r3, r2, r1, r0} = 4'b1111;
    htrans = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      want = {4'b0001 << ((i + 1) % 4), 2'(i % 4), 2'((i > 0 ? i - 1 : 0) % 4), 1'b0};
      n_cmp++;
      if (dut_bus() !== want || dut_bus() !== model_bus()) begin
        n_bad++;
        $display("FAIL round_robin step %0d: got %b want %b", i, dut_bus(), want);
      end
    end
  endtask

  task automatic test_incr4_hold();
    logic [1:0] tr[6];
    logic       rdy[6];
    pulse_reset();
    r1 = 1'b1;
    tick();
    tick();
    r2 = 1'b1;
    tr  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    hburst = 3'b011;
    for (int i = 0; i < 6; i++) begin
      htrans = tr[i];
      hready = rdy[i];
      tick();
      n_cmp++;
      if ({gr3, gr2, gr1, gr0} !== (i < 5 ? 4'b0010 : 4'b0100) || hmaster !== 2'd1
          || dut_bus() !== model_bus()) begin
        n_bad++;
        $display("FAIL incr4_hold beat %0d: got %b want %b", i, dut_bus(), model_bus());
      end
    end
  endtask

  task automatic test_locked();
    pulse_reset();
    r3   = 1'b1;
    lock = 4'b1000;
    tick();
    tick();
    {r2, r1, r0} = 3'b111;
    hburst = 3'b001;
    for (int i = 0; i < 6; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
      n_cmp++;
      if ({gr3, gr2, gr1, gr0} !== 4'b1000 || hmastlock !== 1'b1 || dut_bus() !== model_bus())
      begin
        n_bad++;
        $display("FAIL locked_hold xfer %0d: got %b want %b", i, dut_bus(), model_bus());
      end
    end
    lock   = 4'b0000;
    htrans = 2'b00;
    tick();
    n_cmp++;
    if ({gr3, gr2, gr1, gr0} !== 4'b0001 || dut_bus() !== model_bus()) begin
      n_bad++;
      $display("FAIL locked_exit: got %b want %b", dut_bus(), model_bus());
    end
  endtask

  task automatic test_enable_freeze();
    pulse_reset();
    enable = 1'b0;
    r2     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({gr3, gr2, gr1, gr0} !== 4'b0001 || dut_bus() !== model_bus()) begin
        n_bad++;
        $display("FAIL enable_freeze cyc %0d: got %b want %b", i, dut_bus(), model_bus());
      end
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if ({gr3, gr2, gr1, gr0} !== 4'b0100) begin
      n_bad++;
      $display("FAIL enable_resume: got %b want %b", {gr3, gr2, gr1, gr0}, 4'b0100);
    end
    tick();
    r0     = 1'b1;
    hburst = 3'b101;
    for (int i = 0; i < 3; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
      n_cmp++;
      if ({gr3, gr2, gr1, gr0} !== 4'b0100 || dut_bus() !== model_bus()) begin
        n_bad++;
        $display("FAIL incr8_hold beat %0d: got %b want %b", i, dut_bus(), model_bus());
      end
    end
    htrans = 2'b00;
    tick();
    n_cmp++;
    if ({gr3, gr2, gr1, gr0} !== 4'b0001 || dut_bus() !== model_bus()) begin
      n_bad++;
      $display("FAIL early_term: got %b want %b", dut_bus(), model_bus());
    end
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    r1 = 1'b1;
    tick();
    tick();
    r0     = 1'b1;
    hburst = 3'b111;
    for (int i = 0; i < 5; i++) begin
      htrans = (i == 0) ? 2'b10 : 2'b11;
      tick();
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (dut_bus() !== 9'b0001_00_00_0) begin
      n_bad++;
      $display("FAIL reset_mid_burst: got %b want %b", dut_bus(), 9'b0001_00_00_0);
    end
    reset  = 1'b0;
    r0     = 1'b0;
    htrans = 2'b00;
    tick();
    n_cmp++;
    if ({gr3, gr2, gr1, gr0} !== 4'b0010 || dut_bus() !== model_bus()) begin
      n_bad++;
      $display("FAIL post_reset_arb: got %b want %b", dut_bus(), model_bus());
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 7) != 0);
      hready = ($urandom_range(0, 3) != 0);
      r0 = ($urandom_range(0, 4) < 3);
      r1 = ($urandom_range(0, 4) < 3);
      r2 = ($urandom_range(0, 4) < 2);
      r3 = ($urandom_range(0, 4) < 2);
      for (int m = 0; m < 4; m++) lock[m] = ($urandom_range(0, 5) == 0);
      htrans = 2'($urandom_range(0, 3));
      hburst = 3'($urandom_range(0, 7));
      tick();
      n_cmp++;
      if (dut_bus() !== model_bus() || !$onehot({gr3, gr2, gr1, gr0})) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %b want %b", cyc, dut_bus(), model_bus());
      end
    end
  endtask

  initial begin
    m_grant = DEF; m_ptr = DEF; m_hm = DEF; m_hmd = DEF; m_hml = 0;
    m_mode = "arb"; m_left = 0;
    set_idle();
    test_reset();
    test_round_robin();
    test_incr4_hold();
    test_locked();
    test_enable_freeze();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
